// File: rtl/pbl_arbitro_acesso.sv
// Permission-checked access arbiter for the MATRIZ (0) and LEDS (1) terminals.
// Each terminal runs its own round-robin grant FSM with a bounded hold time.
module pbl_arbitro_acesso #(
    parameter int unsigned N_USERS     = 2,
    parameter int unsigned ID_W        = 3,
    parameter int unsigned FUNC_W      = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    // Default pattern (ID u may use functions 1..u), encoded for ID_W = FUNC_W = 3
    parameter logic [(2**ID_W)*(2**FUNC_W)-1:0] PERM_TABLE = 64'hFE7E_3E1E_0E06_0200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_USERS-1:0]        req,
    input  logic [N_USERS*ID_W-1:0]   user_id,
    input  logic [N_USERS*FUNC_W-1:0] func_sel,
    input  logic [N_USERS-1:0]        tgt,
    output logic [2*N_USERS-1:0]      grant,
    output logic [1:0]                term_valid,
    output logic [2*FUNC_W-1:0]       term_func,
    output logic [2*ID_W-1:0]         term_id,
    output logic [N_USERS-1:0]        deny,
    output logic [1:0]                conflict,
    output logic [7:0]                deny_cnt
);

    localparam int unsigned N_TERM = 2;
    localparam int unsigned PTR_W  = (N_USERS > 1) ? $clog2(N_USERS) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned SUM_W  = 9;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                          state_q [N_TERM];
    state_t                          state_d [N_TERM];
    logic [N_TERM-1:0][N_USERS-1:0]  grant_q, grant_d, elig;
    logic [N_TERM-1:0][PTR_W-1:0]    owner_q, owner_d, rr_q, rr_d;
    logic [N_TERM-1:0][HOLD_W-1:0]   hold_q, hold_d;
    logic [N_TERM-1:0][FUNC_W-1:0]   func_q, func_d;
    logic [N_TERM-1:0][ID_W-1:0]     id_q, id_d;

    logic [N_USERS-1:0] mask_q, mask_d, active, permitted, deny_set, expire_set, deny_q;
    logic [7:0]         cnt_q, cnt_d;
    logic [SUM_W-1:0]   cnt_sum;

    logic               found;
    logic [PTR_W-1:0]   win;
    int                 idx;

    // Per-user permission lookup and per-terminal eligibility
    always_comb begin
        active    = req & ~mask_q;
        permitted = '0;
        elig      = '0;
        for (int i = 0; i < N_USERS; i++) begin
            permitted[i] = (func_sel[i*FUNC_W +: FUNC_W] != '0)
                         && PERM_TABLE[{user_id[i*ID_W +: ID_W], func_sel[i*FUNC_W +: FUNC_W]}];
        end
        deny_set = active & ~permitted;
        // A user owning the other terminal is invisible here until that grant ends
        for (int t = 0; t < N_TERM; t++) begin
            for (int i = 0; i < N_USERS; i++) begin
                elig[t][i] = active[i] && permitted[i] && (tgt[i] == 1'(t))
                           && !grant_q[N_TERM-1-t][i];
            end
        end
    end

    // Contention flag: two or more candidates, or a challenger to the current owner
    always_comb begin
        conflict = '0;
        for (int t = 0; t < N_TERM; t++) begin
            conflict[t] = !rst
                && (((elig[t] & (elig[t] - N_USERS'(1))) != '0)
                    || ((state_q[t] == S_GRANT) && ((elig[t] & ~grant_q[t]) != '0)));
        end
    end

    // Terminal FSMs: next state, round-robin pick and hold timer
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        hold_d     = hold_q;
        func_d     = func_q;
        id_d       = id_q;
        expire_set = '0;
        found      = 1'b0;
        win        = '0;
        idx        = 0;
        for (int t = 0; t < N_TERM; t++) begin
            found = 1'b0;
            win   = '0;
            for (int k = 0; k < N_USERS; k++) begin
                idx = (int'(rr_q[t]) + k) % int'(N_USERS);
                if (!found && elig[t][idx]) begin
                    found = 1'b1;
                    win   = PTR_W'(idx);
                end
            end
            case (state_q[t])
                S_IDLE: begin
                    if (found) begin
                        state_d[t] = S_GRANT;
                        grant_d[t] = N_USERS'(1) << win;
                        owner_d[t] = win;
                        hold_d[t]  = HOLD_W'(1);
                        rr_d[t]    = (win == PTR_W'(N_USERS - 1)) ? '0 : win + PTR_W'(1);
                        func_d[t]  = func_sel[int'(win)*FUNC_W +: FUNC_W];
                        id_d[t]    = user_id[int'(win)*ID_W +: ID_W];
                    end
                end
                S_GRANT: begin
                    if (!req[owner_q[t]] || (hold_q[t] >= HOLD_W'(HOLD_CYCLES))) begin
                        // Timed-out owner must toggle req before it can compete again
                        if (req[owner_q[t]]) begin
                            expire_set[owner_q[t]] = 1'b1;
                        end
                        state_d[t] = S_IDLE;
                        grant_d[t] = '0;
                        hold_d[t]  = '0;
                        func_d[t]  = '0;
                        id_d[t]    = '0;
                    end else begin
                        hold_d[t] = hold_q[t] + HOLD_W'(1);
                    end
                end
                default: state_d[t] = S_IDLE;
            endcase
        end
    end

    // Deny counter (saturating) and retry mask
    always_comb begin
        cnt_sum = SUM_W'(cnt_q) + SUM_W'($countones(deny_set));
        cnt_d   = (cnt_sum > SUM_W'(255)) ? 8'hFF : cnt_sum[7:0];
        mask_d  = (mask_q | deny_set | expire_set) & req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < N_TERM; t++) begin
                state_q[t] <= S_IDLE;
            end
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            func_q  <= '0;
            id_q    <= '0;
            mask_q  <= '0;
            deny_q  <= '0;
            cnt_q   <= '0;
        end else begin
            for (int t = 0; t < N_TERM; t++) begin
                state_q[t] <= state_d[t];
            end
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            func_q  <= func_d;
            id_q    <= id_d;
            mask_q  <= mask_d;
            deny_q  <= deny_set;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        term_valid = '0;
        for (int t = 0; t < N_TERM; t++) begin
            term_valid[t] = (state_q[t] == S_GRANT);
        end
    end

    assign grant     = grant_q;
    assign term_func = func_q;
    assign term_id   = id_q;
    assign deny      = deny_q;
    assign deny_cnt  = cnt_q;

endmodule

// File: tb/tb_pbl_arbitro_acesso.sv
// Scoreboard bench for pbl_arbitro_acesso: directed and randomized stimulus
// checked against a cycle-level behavioural model of the access rules.
module tb_pbl_arbitro_acesso;

    localparam int N    = 3;
    localparam int IW   = 3;
    localparam int FW   = 3;
    localparam int HOLD = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, tgt;
    logic [N*IW-1:0] user_id;
    logic [N*FW-1:0] func_sel;
    logic [2*N-1:0]  grant;
    logic [1:0]      term_valid, conflict;
    logic [2*FW-1:0] term_func;
    logic [2*IW-1:0] term_id;
    logic [N-1:0]    deny;
    logic [7:0]      deny_cnt;

    pbl_arbitro_acesso #(
        .N_USERS(N), .ID_W(IW), .FUNC_W(FW), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .user_id(user_id), .func_sel(func_sel),
        .tgt(tgt), .grant(grant), .term_valid(term_valid), .term_func(term_func),
        .term_id(term_id), .deny(deny), .conflict(conflict), .deny_cnt(deny_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*N-1:0]  grant;
        logic [1:0]      valid;
        logic [2*FW-1:0] func;
        logic [2*IW-1:0] id;
        logic [N-1:0]    deny;
        logic [7:0]      cnt;
        logic [1:0]      conflict;
    } exp_t;

    exp_t exp_q [$];
    int   errors = 0;
    int   checks = 0;

    // Stimulus currently applied
    bit s_rst;
    bit s_req [N];
    int s_id [N];
    int s_func [N];
    int s_tgt [N];

    // Reference model state (owner -1 = terminal free)
    int m_owner [2];
    int m_age [2];
    int m_rr [2];
    int m_func [2];
    int m_id [2];
    bit m_mask [N];
    bit m_deny [N];
    int m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic bit allowed(int id, int f);
        return (f >= 1) && (f <= id);
    endfunction

    function automatic bit eligible(int i, int t);
        return s_req[i] && !m_mask[i] && allowed(s_id[i], s_func[i])
            && (s_tgt[i] == t) && (m_owner[1-t] != i);
    endfunction

    task automatic model_reset();
        for (int t = 0; t < 2; t++) begin
            m_owner[t] = -1; m_age[t] = 0; m_rr[t] = 0; m_func[t] = 0; m_id[t] = 0;
        end
        for (int i = 0; i < N; i++) begin
            m_mask[i] = 0; m_deny[i] = 0;
        end
        m_cnt = 0;
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e = '{default: '0};
        for (int t = 0; t < 2; t++) begin
            if (m_owner[t] >= 0) begin
                e.grant[t*N + m_owner[t]] = 1'b1;
                e.valid[t] = 1'b1;
                e.func[t*FW +: FW] = FW'(m_func[t]);
                e.id[t*IW +: IW]   = IW'(m_id[t]);
            end
        end
        for (int i = 0; i < N; i++) e.deny[i] = m_deny[i];
        e.cnt = 8'(m_cnt);
        if (!s_rst) begin
            for (int t = 0; t < 2; t++) begin
                int n = 0;
                bit challenger = 0;
                for (int i = 0; i < N; i++) begin
                    if (eligible(i, t)) begin
                        n++;
                        if (i != m_owner[t]) challenger = 1;
                    end
                end
                e.conflict[t] = (n >= 2) || ((m_owner[t] >= 0) && challenger);
            end
        end
        return e;
    endfunction

    task automatic model_advance();
        bit el [2][N];
        bit expire [N];
        int nd = 0;
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < N; i++) el[t][i] = eligible(i, t);
        for (int i = 0; i < N; i++) begin
            expire[i] = 0;
            m_deny[i] = s_req[i] && !m_mask[i] && !allowed(s_id[i], s_func[i]);
            if (m_deny[i]) nd++;
        end
        for (int t = 0; t < 2; t++) begin
            if (m_owner[t] < 0) begin
                for (int k = 0; k < N; k++) begin
                    int c = (m_rr[t] + k) % N;
                    if (el[t][c]) begin
                        m_owner[t] = c; m_age[t] = 1; m_rr[t] = (c + 1) % N;
                        m_func[t] = s_func[c]; m_id[t] = s_id[c];
                        break;
                    end
                end
            end else if (!s_req[m_owner[t]] || m_age[t] == HOLD) begin
                if (s_req[m_owner[t]]) expire[m_owner[t]] = 1;
                m_owner[t] = -1; m_func[t] = 0; m_id[t] = 0; m_age[t] = 0;
            end else begin
                m_age[t]++;
            end
        end
        for (int i = 0; i < N; i++) m_mask[i] = s_req[i] && (m_mask[i] || m_deny[i] || expire[i]);
        m_cnt = (m_cnt + nd > 255) ? 255 : m_cnt + nd;
    endtask

    // Apply stimulus, queue the expected response for this cycle, advance one edge
    task automatic step();
        rst = s_rst;
        for (int i = 0; i < N; i++) begin
            req[i] = s_req[i];
            tgt[i] = (s_tgt[i] != 0);
            user_id[i*IW +: IW]  = IW'(s_id[i]);
            func_sel[i*FW +: FW] = FW'(s_func[i]);
        end
        if (s_rst) model_reset();
        exp_q.push_back(model_outputs());
        if (!s_rst) model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_user(int i, bit r, int id, int f, int t);
        s_req[i] = r; s_id[i] = id; s_func[i] = f; s_tgt[i] = t;
    endtask

    task automatic clear_users();
        for (int i = 0; i < N; i++) set_user(i, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        clear_users();
        s_rst = 1;
        step();
        s_rst = 0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("grant", grant, e.grant);
            check("term_valid", term_valid, e.valid);
            check("term_func", term_func, e.func);
            check("term_id", term_id, e.id);
            check("deny", deny, e.deny);
            check("deny_cnt", deny_cnt, e.cnt);
            check("conflict", conflict, e.conflict);
        end
    end

    initial begin
        int c0, c1, f0, f1;
        clear_users();
        s_rst = 1;
        rst = 1; req = '0; tgt = '0; user_id = '0; func_sel = '0;
        model_reset();
        @(posedge clk);
        #1;
        step();
        step();
        s_rst = 0;

        // Single grant, then release after req drops
        set_user(0, 1, 5, 3, 0);
        repeat (5) step();
        check("single_grant", grant, 6'b000001);
        check("single_func", term_func, 6'b000011);
        check("single_id", term_id, 6'b000101);
        s_req[0] = 0;
        step();
        check("single_release", term_valid, 2'b00);

        // Asynchronous reset while user0 owns terminal 0
        s_req[0] = 1;
        repeat (3) step();
        check("pre_reset_grant", grant, 6'b000001);
        clear_users();
        s_rst = 1;
        step();
        s_rst = 0;

        // Deny pulse, no repeat while held, retry after toggle
        do_reset();
        set_user(1, 1, 2, 4, 0);
        step();
        check("deny_pulse1", deny, 3'b010);
        check("deny_cnt1", deny_cnt, 8'd1);
        step();
        check("deny_held", deny, 3'b000);
        s_req[1] = 0;
        step();
        s_req[1] = 1;
        step();
        check("deny_pulse2", deny, 3'b010);
        check("deny_cnt2", deny_cnt, 8'd2);

        // Round-robin on LEDS with contention
        do_reset();
        set_user(0, 1, 5, 3, 1);
        set_user(1, 1, 3, 1, 1);
        step();
        check("rr_first", grant, 6'b001000);
        repeat (2) step();
        s_req[0] = 0;
        step();
        check("rr_bubble", grant, 6'b000000);
        s_req[0] = 1;
        step();
        check("rr_second", grant, 6'b010000);

        // Hold timeout with a waiting second user
        do_reset();
        set_user(0, 1, 5, 3, 0);
        set_user(1, 1, 3, 2, 0);
        c0 = 0; c1 = 0; f0 = -1; f1 = -1;
        for (int k = 0; k < 45; k++) begin
            if (k == 40) s_req[0] = 0;
            step();
            if (grant[0]) begin c0++; if (f0 < 0) f0 = k; end
            if (grant[1]) begin c1++; if (f1 < 0) f1 = k; end
        end
        check("timeout_len0", 64'(c0), 64'd16);
        check("timeout_len1", 64'(c1), 64'd16);
        check("timeout_bubble", 64'(f1 - f0), 64'd17);

        // Both terminals granted on the same edge
        do_reset();
        set_user(0, 1, 5, 3, 0);
        set_user(1, 1, 4, 2, 1);
        step();
        check("dual_grant", grant, 6'b010001);
        check("dual_func", term_func, 6'b010011);
        check("dual_id", term_id, 6'b100101);
        check("dual_conflict", conflict, 2'b00);

        // Deny counter saturation
        do_reset();
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < N; i++) set_user(i, 1, 0, 1, i % 2);
            step();
            for (int i = 0; i < N; i++) s_req[i] = 0;
            step();
        end
        check("deny_saturate", deny_cnt, 8'd255);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            s_rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (s_req[i]) begin
                    if ($urandom_range(0, 9) == 0) s_req[i] = 0;
                    else if ($urandom_range(0, 19) == 0) begin
                        s_func[i] = int'($urandom_range(0, 7));
                        s_tgt[i]  = int'($urandom_range(0, 1));
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    int hi;
                    s_req[i] = 1;
                    s_id[i]  = int'($urandom_range(0, 7));
                    hi = (s_id[i] < 1) ? 1 : s_id[i];
                    s_func[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                                           : int'($urandom_range(1, hi));
                    s_tgt[i] = int'($urandom_range(0, 1));
                end
            end
            step();
        end

        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pbl_arbitro_acesso.md
Name: pbl_arbitro_acesso

Overview:
- Registered, parametrised successor to the two-user combinational access controller.
- Accepts N user requests. Each request carries a user ID, a functionality code and a target terminal (0 = MATRIZ, 1 = LEDS).
- Checks permission against a parameter table and arbitrates each terminal round-robin.
- Holds each grant for a bounded time and drives registered terminal outputs to the existing matriz/leds/7-seg decoders.

Parameters:
- N_USERS, 2, number of requesting users (2..8).
- ID_W, 3, user ID width.
- FUNC_W, 3, functionality code width; code 0 = "none", always denied.
- HOLD_CYCLES, 16, maximum grant length in clocks (≥2).
- PERM_TABLE, default pattern, (2^ID_W)*(2^FUNC_W) bits; bit [u*2^FUNC_W + f] = 1 means ID u may use function f. Default: ID u allows f for 1 ≤ f ≤ u; ID 0 allows nothing.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_USERS  per-user request level.
- user_id  in  N_USERS*ID_W  packed IDs; user i at [i*ID_W +: ID_W].
- func_sel  in  N_USERS*FUNC_W  packed functionality codes.
- tgt  in  N_USERS  per-user target terminal.
- grant  out  2*N_USERS  one-hot owner per terminal; terminal t at [t*N_USERS +: N_USERS].
- term_valid  out  2  terminal t owned.
- term_func  out  2*FUNC_W  function latched at grant; 0 when idle.
- term_id  out  2*ID_W  owner ID latched at grant; 0 when idle.
- deny  out  N_USERS  one-cycle pulse on permission refusal.
- conflict  out  2  ≥2 eligible requests contend for terminal t this cycle.
- deny_cnt  out  8  saturating count of deny pulses.

Behaviour:
- Reset: clk and rst only; reset is asynchronous and active-high.
  - On rst, all outputs are 0, all FSMs go to IDLE, RR pointers = 0 and all user masks are cleared.
  - Reset mid-grant drops the grant immediately (asynchronously).
- Eligibility (combinational, per user i):
  - Active means req[i]=1 and mask[i]=0.
  - Permitted means PERM_TABLE[user_id_i*2^FUNC_W + func_i] = 1.
  - Eligible for terminal t means active, permitted, and tgt[i]=t.
- Deny path:
  - Every active, non-permitted user pulses deny[i] for exactly one cycle (registered, one clock after sampling) and sets mask[i].
  - Several users can be denied in the same cycle.
  - deny_cnt adds the popcount of the pulses and saturates at 255.
- Mask: mask[i] clears only when req[i]=0 is sampled. A requester must drop req and raise it again to retry.
- Per-terminal FSM (two independent instances):
  - IDLE:
    - If any user is eligible, pick the first eligible index at or after rr_ptr[t], wrapping modulo N_USERS.
    - Next edge: grant bit set, term_valid=1, term_func/term_id latched, hold counter=1, rr_ptr[t] = winner+1 (wrapping). Go to GRANT.
    - Latency: req sampled at edge k gives grant at edge k+1.
  - GRANT:
    - Outputs are frozen; changes to func_sel/user_id/tgt are ignored.
    - Owner drops req: next edge releases (outputs to 0) and returns to IDLE. No new grant in the same edge.
    - Hold counter reaches HOLD_CYCLES while req is still high: release, set the owner's mask, return to IDLE.
    - Release always takes one IDLE cycle before the next grant (1-cycle bubble).
- Shared user: a user cannot own both terminals. If tgt changes while the user is granted, the other terminal treats it as ineligible until its grant ends.
- Tie between terminals on the same edge: never arises, because each user targets exactly one terminal.
- conflict[t]: combinational, equal to (count of eligible users for t ≥ 2) or (term_valid[t] and ≥1 non-owner eligible for t).
- Round-robin pointer update: only on grant, never on deny.
- Mid-operation deny: when deny and grant decisions happen on the same edge for different users, both take effect.

Test Plan:
- Reset then idle: rst=1 mid-cycle, with user0 granted on terminal 0 → grant, term_valid, term_func, deny and deny_cnt all 0 immediately, not waiting for the clock edge.
- Single grant: user0 id=5, func=3, tgt=0, req rises at edge 1 → grant[0]=1, term_func[0]=3, term_id[0]=5 from edge 2. req falls at edge 6 → term_valid[0]=0 at edge 7.
- Deny: user1 id=2, func=4 → deny[1] high exactly one cycle, deny_cnt=1. Holding req high produces no further pulses. Drop and raise req → second pulse, deny_cnt=2.
- Round-robin and conflict: users 0 and 1 both eligible on tgt=1 from reset → conflict[1]=1. User0 is granted first. After user0 releases, one idle cycle, then user1 is granted while user0 re-requests.
- Timeout: user0 holds req for 40 cycles with HOLD_CYCLES=16 → grant lasts exactly 16 cycles. User0 gets no regrant until req toggles. A waiting user1 is granted after the one-cycle bubble.
- Dual terminals plus saturation: user0→tgt0 and user1→tgt1 simultaneously, both permitted → both granted on the same edge, conflict=0. Separately, 300 deny events → deny_cnt=255.
